// File: rtl/exec_stage_unit.sv
// Execute stage: 16-bit ALU with flags, branch/set condition, CLA PC-target adder and next-PC/link selection.
// Optional macro EXEC_DEBUG_DISPLAY_EN prints invA changes in simulation; the logic is the same either way.
module exec_stage_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        SLBIsel,
  input  logic [15:0] incPC,
  input  logic        immSrc,
  input  logic [15:0] imm8,
  input  logic [15:0] imm11,
  input  logic [2:0]  brchSig,
  input  logic        Cin,
  input  logic [15:0] inA,
  input  logic [15:0] inB,
  input  logic        invA,
  input  logic        invB,
  input  logic [3:0]  aluOp,
  input  logic        aluJmp,
  input  logic        jalSel,
  input  logic        sOpSel,
  input  logic        aluPC,
  output logic [15:0] aluOut,
  output logic [15:0] aluFinal,
  output logic [15:0] newPC,
  output logic [15:0] addPC
);

  localparam int unsigned DW = 16;
  localparam int unsigned NG = 4;

  logic [DW-1:0]   w_a, w_b, w_alu, w_rev;
  logic [3:0]      w_sh;
  logic [2*DW-1:0] w_rol_dbl, w_ror_dbl;
  logic [DW:0]     w_sum;
  logic            w_cout, w_ofl, w_zero, w_sign, w_lt, w_jmp_sel;

  logic [DW-1:0]   w_base, w_off, w_g, w_p, w_comp_pc, w_jmp_pc;
  logic [NG-1:0]   w_gg, w_gp, w_gc;

  logic [DW-1:0]   r_alu_out, r_alu_final, r_new_pc, r_add_pc;

  // 4-bit lookahead sum for one group given its carry-in.
  function automatic logic [3:0] cla_sum4(input logic [3:0] g, input logic [3:0] p,
                                          input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return p ^ c;
  endfunction

  assign w_a  = invA ? ~inA : inA;
  assign w_b  = invB ? ~inB : inB;
  assign w_sh = w_b[3:0];

  assign w_rol_dbl = {w_a, w_a} << w_sh;
  assign w_ror_dbl = {w_a, w_a} >> w_sh;
  assign w_sum     = (DW+1)'(w_a) + (DW+1)'(w_b) + (DW+1)'(Cin);

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < DW; i++) begin
      w_rev[i] = w_a[DW-1-i];
    end
  end

  // ALU result; carry and overflow only meaningful for the add.
  always_comb begin
    w_alu  = '0;
    w_cout = 1'b0;
    w_ofl  = 1'b0;
    case (aluOp)
      4'b0000: w_alu = w_rol_dbl[2*DW-1:DW];
      4'b0001: w_alu = w_a << w_sh;
      4'b0010: w_alu = w_ror_dbl[DW-1:0];
      4'b0011: w_alu = w_a >> w_sh;
      4'b0100: begin
        w_alu  = w_sum[DW-1:0];
        w_cout = w_sum[DW];
        w_ofl  = (w_a[DW-1] == w_b[DW-1]) && (w_sum[DW-1] != w_a[DW-1]);
      end
      4'b0101: w_alu = w_a & w_b;
      4'b0110: w_alu = w_a | w_b;
      4'b0111: w_alu = w_a ^ w_b;
      4'b1000: w_alu = w_rev;
      4'b1001: w_alu = {w_a[7:0], w_b[7:0]};
      4'b1010: w_alu = w_b;
      4'b1011: w_alu = w_a;
      default: w_alu = '0;
    endcase
  end

  assign w_zero = (w_alu == '0);
  assign w_sign = w_alu[DW-1];
  assign w_lt   = w_sign ^ w_ofl;

  always_comb begin
    w_jmp_sel = 1'b0;
    case (brchSig)
      3'b000: w_jmp_sel = 1'b0;
      3'b001: w_jmp_sel = 1'b1;
      3'b010: w_jmp_sel = w_zero;
      3'b011: w_jmp_sel = ~w_zero;
      3'b100: w_jmp_sel = w_lt;
      3'b101: w_jmp_sel = ~w_lt;
      3'b110: w_jmp_sel = w_zero | w_lt;
      3'b111: w_jmp_sel = w_cout;
      default: w_jmp_sel = 1'b0;
    endcase
  end

  assign w_base = aluPC ? w_alu : incPC;
  assign w_off  = immSrc ? imm11 : imm8;
  assign w_g    = w_base & w_off;
  assign w_p    = w_base ^ w_off;

  // Group generate/propagate for the two-level lookahead.
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < NG; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
  end

  assign w_gc[0] = 1'b0;
  assign w_gc[1] = w_gg[0];
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0]);

  always_comb begin
    w_comp_pc = '0;
    for (int k = 0; k < NG; k++) begin
      w_comp_pc[4*k +: 4] = cla_sum4(w_g[4*k +: 4], w_p[4*k +: 4], w_gc[k]);
    end
  end

  assign w_jmp_pc = w_jmp_sel ? w_comp_pc : incPC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out   <= '0;
      r_alu_final <= '0;
      r_new_pc    <= '0;
      r_add_pc    <= '0;
    end else begin
      r_alu_out   <= w_alu;
      r_alu_final <= sOpSel ? {{(DW-1){1'b0}}, w_jmp_sel} : w_alu;
      r_new_pc    <= SLBIsel ? incPC : (aluJmp ? w_alu : w_jmp_pc);
      r_add_pc    <= jalSel ? incPC : w_jmp_pc;
    end
  end

  assign aluOut   = r_alu_out;
  assign aluFinal = r_alu_final;
  assign newPC    = r_new_pc;
  assign addPC    = r_add_pc;

`ifdef EXEC_DEBUG_DISPLAY_EN
  always @(invA) begin
    $display("invA in execute:  %b", invA);
  end
`endif

endmodule

// File: tb/tb_exec_stage_unit.sv
// Directed plus randomized bench for exec_stage_unit against an arithmetic reference model.
module tb_exec_stage_unit;

  logic        clk, rst, SLBIsel, immSrc, Cin, invA, invB, aluJmp, jalSel, sOpSel, aluPC;
  logic [15:0] incPC, imm8, imm11, inA, inB;
  logic [2:0]  brchSig;
  logic [3:0]  aluOp;
  logic [15:0] aluOut, aluFinal, newPC, addPC;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_v;

  exec_stage_unit dut (
    .clk(clk), .rst(rst), .SLBIsel(SLBIsel), .incPC(incPC), .immSrc(immSrc),
    .imm8(imm8), .imm11(imm11), .brchSig(brchSig), .Cin(Cin), .inA(inA), .inB(inB),
    .invA(invA), .invB(invB), .aluOp(aluOp), .aluJmp(aluJmp), .jalSel(jalSel),
    .sOpSel(sOpSel), .aluPC(aluPC), .aluOut(aluOut), .aluFinal(aluFinal),
    .newPC(newPC), .addPC(addPC)
  );

  always #5 clk = ~clk;

  // Reference: {aluOut, aluFinal, newPC, addPC} for the current inputs.
  function automatic logic [63:0] model();
    logic [15:0] a, b, r, t, base, off, comp, jpc;
    int unsigned sh, us;
    int ss;
    logic cout, ofl, zero, lt, jsel;
    if (rst) return 64'h0;
    a = invA ? ~inA : inA;
    b = invB ? ~inB : inB;
    sh = int'(b) % 16;
    r = 16'h0; cout = 1'b0; ofl = 1'b0;
    case (aluOp)
      4'd0: begin t = a; for (int i = 0; i < 16; i++) if (i < sh) t = {t[14:0], t[15]}; r = t; end
      4'd1: r = 16'((int'(a) * (1 << sh)) % 65536);
      4'd2: begin t = a; for (int i = 0; i < 16; i++) if (i < sh) t = {t[0], t[15:1]}; r = t; end
      4'd3: r = 16'(int'(a) / (1 << sh));
      4'd4: begin
        us = int'(a) + int'(b) + int'(Cin);
        r = 16'(us % 65536);
        cout = (us >= 65536);
        ss = int'($signed(a)) + int'($signed(b)) + int'(Cin);
        ofl = (ss > 32767) || (ss < -32768);
      end
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: for (int i = 0; i < 16; i++) r[i] = a[15-i];
      4'd9: r = 16'((int'(a) * 256 + int'(b) % 256) % 65536);
      4'd10: r = b;
      4'd11: r = a;
      default: r = 16'h0;
    endcase
    zero = (r == 16'h0);
    lt   = r[15] ^ ofl;
    case (brchSig)
      3'd0: jsel = 1'b0;
      3'd1: jsel = 1'b1;
      3'd2: jsel = zero;
      3'd3: jsel = !zero;
      3'd4: jsel = lt;
      3'd5: jsel = !lt;
      3'd6: jsel = zero || lt;
      default: jsel = cout;
    endcase
    base = aluPC ? r : incPC;
    off  = immSrc ? imm11 : imm8;
    comp = 16'((int'(base) + int'(off)) % 65536);
    jpc  = jsel ? comp : incPC;
    return {r, (sOpSel ? {15'h0, jsel} : r),
            (SLBIsel ? incPC : (aluJmp ? r : jpc)),
            (jalSel ? incPC : jpc)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply current inputs for one edge, then compare all outputs to the model.
  task automatic step(input string tag);
    exp_v = model();
    @(posedge clk);
    #1;
    chk({tag, ".aluOut"},   aluOut,   exp_v[63:48]);
    chk({tag, ".aluFinal"}, aluFinal, exp_v[47:32]);
    chk({tag, ".newPC"},    newPC,    exp_v[31:16]);
    chk({tag, ".addPC"},    addPC,    exp_v[15:0]);
  endtask

  task automatic clear_inputs();
    SLBIsel = 0; immSrc = 0; Cin = 0; invA = 0; invB = 0; aluJmp = 0; jalSel = 0;
    sOpSel = 0; aluPC = 0; incPC = 0; imm8 = 0; imm11 = 0; inA = 0; inB = 0;
    brchSig = 0; aluOp = 0;
  endtask

  task automatic rand_inputs();
    {SLBIsel, immSrc, Cin, invA, invB} = 5'($urandom);
    {aluJmp, jalSel, sOpSel, aluPC} = 4'($urandom);
    incPC = 16'($urandom); imm8 = 16'($urandom); imm11 = 16'($urandom);
    inA = 16'($urandom); inB = 16'($urandom);
    brchSig = 3'($urandom); aluOp = 4'($urandom);
  endtask

  initial begin
    clk = 0;
    rst = 1;
    rand_inputs();
    #2;
    step("reset0");
    chk("reset0.zero", newPC, 16'h0000);
    rand_inputs();
    step("reset1");
    rst = 0;

    clear_inputs();
    inA = 16'h7FFF; inB = 16'h0001; aluOp = 4'b0100; brchSig = 3'b100; sOpSel = 1;
    step("add_ofl");
    chk("add_ofl.out", aluOut, 16'h8000);
    chk("add_ofl.jmp", aluFinal, 16'h0000);

    clear_inputs();
    inA = 16'd3; inB = 16'd5; invB = 1; Cin = 1; aluOp = 4'b0100; brchSig = 3'b100; sOpSel = 1;
    step("slt");
    chk("slt.final", aluFinal, 16'h0001);

    clear_inputs();
    incPC = 16'h0010; imm8 = 16'hFFF8; aluOp = 4'b1011; brchSig = 3'b010;
    step("beqz_taken");
    chk("beqz_taken.newPC", newPC, 16'h0008);
    chk("beqz_taken.addPC", addPC, 16'h0008);
    inA = 16'h0001;
    step("beqz_not");
    chk("beqz_not.newPC", newPC, 16'h0010);

    clear_inputs();
    incPC = 16'h0042; aluPC = 1; aluJmp = 1; jalSel = 1; inA = 16'h0100; aluOp = 4'b1011;
    step("jalr");
    chk("jalr.newPC", newPC, 16'h0100);
    chk("jalr.addPC", addPC, 16'h0042);

    clear_inputs();
    inA = 16'h8001; inB = 16'h0001; incPC = 16'h0200; imm8 = 16'h0020; brchSig = 3'b001;
    step("rol");
    chk("rol.out", aluOut, 16'h0003);
    aluOp = 4'b0011;
    step("srl");
    chk("srl.out", aluOut, 16'h4000);
    aluOp = 4'b1001; inB = 16'h00AB; SLBIsel = 1; aluJmp = 1;
    step("slbi");
    chk("slbi.out", aluOut, 16'h01AB);
    chk("slbi.newPC", newPC, 16'h0200);

    clear_inputs();
    incPC = 16'hFFFE; imm8 = 16'h0004; brchSig = 3'b001;
    step("pc_wrap");
    chk("pc_wrap.newPC", newPC, 16'h0002);
    inA = 16'hFFFE; inB = 16'h0004; aluOp = 4'b0100; brchSig = 3'b111; sOpSel = 1; incPC = 16'h1000;
    step("add_wrap");
    chk("add_wrap.out", aluOut, 16'h0002);
    chk("add_wrap.cout", aluFinal, 16'h0001);

    // Reset mid-stream discards the in-flight result.
    rand_inputs();
    rst = 1;
    step("midrst");
    chk("midrst.aluOut", aluOut, 16'h0000);
    rst = 0;

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      rst = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
